// File: rtl/breakout_ball.sv
// Ball motion controller for Breakout: owns ball position/direction, runs the
// serve/play/lost/game-over sequence and tracks the remaining lives.
module breakout_ball #(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600,
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE_X   = 770,
  parameter int START_X    = 700,
  parameter int START_Y    = 296,
  parameter int STEP_DIV   = 100000,
  parameter int LOST_TICKS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        serve,
  input  logic [10:0] paddle_y_t,
  input  logic [10:0] paddle_y_b,
  input  logic        moveU,
  input  logic        moveD,
  input  logic        moveL,
  input  logic        moveR,
  output logic [10:0] ball_x_l,
  output logic [10:0] ball_x_r,
  output logic [10:0] ball_y_t,
  output logic [10:0] ball_y_b,
  output logic        ball_ON,
  output logic [1:0]  lives,
  output logic        ball_lost,
  output logic        game_over
);

  typedef enum logic [1:0] {IDLE, PLAY, LOST, OVER} state_t;

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int LT_W  = $clog2(LOST_TICKS + 1);

  localparam logic [10:0] EDGE_OFS  = 11'(BALL_SIZE - 1);
  localparam logic [10:0] START_X_L = 11'(START_X);
  localparam logic [10:0] START_Y_T = 11'(START_Y);
  localparam logic [10:0] LOSS_X_R  = 11'(SCREEN_W - 1);
  localparam logic [10:0] BOTTOM_YB = 11'(SCREEN_H - 1);
  localparam logic [10:0] Y_T_MAX   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] PADDLE_L  = 11'(PADDLE_X);
  localparam logic [10:0] PADDLE_R  = 11'(PADDLE_X + 3);

  state_t            state;
  logic [CNT_W-1:0]  step_cnt;
  logic [LT_W-1:0]   lost_cnt;
  logic              dir_right;
  logic              dir_down;
  logic              tick;
  logic              hit_paddle;
  logic              next_dir_right;
  logic              next_dir_down;

  assign ball_x_r = ball_x_l + EDGE_OFS;
  assign ball_y_b = ball_y_t + EDGE_OFS;

  assign tick = ((state == PLAY) || (state == LOST)) &&
                (step_cnt == CNT_W'(STEP_DIV - 1));

  assign ball_ON = ((state == IDLE) || (state == PLAY)) &&
                   (pix_x >= ball_x_l) && (pix_x <= ball_x_r) &&
                   (pix_y >= ball_y_t) && (pix_y <= ball_y_b);

  assign hit_paddle = dir_right &&
                      (ball_x_r >= PADDLE_L) && (ball_x_r <= PADDLE_R) &&
                      (ball_y_b >= paddle_y_t) && (ball_y_t <= paddle_y_b);

  // Walls and paddle outrank column bounce requests; opposing requests cancel.
  always_comb begin
    next_dir_right = dir_right;
    if (ball_x_l == 11'd0)
      next_dir_right = 1'b1;
    else if (hit_paddle)
      next_dir_right = 1'b0;
    else if (moveL && !moveR)
      next_dir_right = 1'b0;
    else if (moveR && !moveL)
      next_dir_right = 1'b1;

    next_dir_down = dir_down;
    if (ball_y_t == 11'd0)
      next_dir_down = 1'b1;
    else if (ball_y_b >= BOTTOM_YB)
      next_dir_down = 1'b0;
    else if (moveU && !moveD)
      next_dir_down = 1'b0;
    else if (moveD && !moveU)
      next_dir_down = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ball_x_l  <= START_X_L;
      ball_y_t  <= START_Y_T;
      dir_right <= 1'b0;
      dir_down  <= 1'b0;
      lives     <= 2'd3;
      ball_lost <= 1'b0;
      game_over <= 1'b0;
      step_cnt  <= '0;
      lost_cnt  <= '0;
    end else begin
      ball_lost <= 1'b0;
      if ((state == PLAY) || (state == LOST))
        step_cnt <= tick ? '0 : step_cnt + 1'b1;
      else
        step_cnt <= '0;

      case (state)
        IDLE: begin
          ball_x_l <= START_X_L;
          ball_y_t <= START_Y_T;
          if (serve) begin
            state     <= PLAY;
            dir_right <= 1'b0;
            dir_down  <= 1'b0;
          end
        end
        PLAY: begin
          dir_right <= next_dir_right;
          dir_down  <= next_dir_down;
          // The loss check runs before the move, so the ball freezes at the edge.
          if (tick) begin
            if (ball_x_r >= LOSS_X_R) begin
              state     <= LOST;
              ball_lost <= 1'b1;
              lost_cnt  <= '0;
              lives     <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            end else begin
              if (dir_right)
                ball_x_l <= ball_x_l + 11'd1;
              else if (ball_x_l != 11'd0)
                ball_x_l <= ball_x_l - 11'd1;
              if (dir_down) begin
                if (ball_y_t < Y_T_MAX)
                  ball_y_t <= ball_y_t + 11'd1;
              end else if (ball_y_t != 11'd0) begin
                ball_y_t <= ball_y_t - 11'd1;
              end
            end
          end
        end
        LOST: begin
          if (tick) begin
            if (lost_cnt == LT_W'(LOST_TICKS - 1)) begin
              lost_cnt <= '0;
              if (lives != 2'd0) begin
                state    <= IDLE;
                ball_x_l <= START_X_L;
                ball_y_t <= START_Y_T;
              end else begin
                state     <= OVER;
                game_over <= 1'b1;
              end
            end else begin
              lost_cnt <= lost_cnt + 1'b1;
            end
          end
        end
        OVER: begin
          game_over <= 1'b1;
        end
      endcase
    end
  end

endmodule
